// File: rtl/amm_mem_pkg.sv
// Shared types and helpers for the Avalon-MM dual-port memory.
// The optional power-up clear sequence is enabled with the AMM_MEM_CLEAR_EN macro.
package amm_mem_pkg;

    localparam int MAX_RD_LATENCY = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } mem_state_e;

    // Keeps the read pipeline depth inside 1..MAX_RD_LATENCY.
    function automatic int clamp_latency(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > MAX_RD_LATENCY) begin
            return MAX_RD_LATENCY;
        end
        return lat;
    endfunction

    // $clog2 that never yields a zero-width vector.
    function automatic int safe_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/amm_rd_latency_pipe.sv
// Fixed-depth valid/data shift register carrying read returns to the port.
// A synchronous flush drops every word still in flight.
module amm_rd_latency_pipe
    import amm_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  ret_valid,
    output logic [DATA_WIDTH-1:0] ret_data
);

    localparam int STAGES = clamp_latency(DEPTH);

    logic [STAGES-1:0]     vld;
    logic [DATA_WIDTH-1:0] dat [STAGES];

    // Empty slots carry zero so readdata never shows stale or undefined words.
    always_ff @(posedge clk) begin
        if (flush) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= push_valid;
            dat[0] <= push_valid ? push_data : '0;
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign ret_valid = vld[STAGES-1];
    assign ret_data  = dat[STAGES-1];

endmodule

// File: rtl/amm_dual_port_mem.sv
// Avalon-MM memory with a fixed-latency read port, byte-enabled write port and
// periodic waitrequest throttle. Define AMM_MEM_CLEAR_EN to zero the array after reset.
module amm_dual_port_mem
    import amm_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 10,
    parameter int BYTE_CNT    = DATA_WIDTH / 8,
    parameter int RD_LATENCY  = 2,
    parameter int WAIT_PERIOD = 4
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
    input  logic                  amm_rd_read_i,
    output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
    output logic                  amm_rd_readdatavalid_o,
    output logic                  amm_rd_waitrequest_o,
    input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
    input  logic                  amm_wr_write_i,
    input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
    input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
    output logic                  amm_wr_waitrequest_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LAT   = clamp_latency(RD_LATENCY);
    localparam int CNT_W = safe_clog2(WAIT_PERIOD);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wait_q;
    logic             stall;
    logic             run;
    logic             clearing;
    logic             clr_last;
    logic             rd_accept;
    logic             wr_accept;
    logic [DATA_WIDTH-1:0] rd_word;

    function automatic logic thr_at(input logic [CNT_W-1:0] c);
        return (WAIT_PERIOD != 0) && (c == CNT_W'(WAIT_PERIOD - 1));
    endfunction

`ifdef AMM_MEM_CLEAR_EN
    localparam logic WAIT_RST = 1'b1;

    mem_state_e            state;
    mem_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] clr_addr;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clr_last  = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                clr_last = (clr_addr == {ADDR_WIDTH{1'b1}});
                if (clr_last) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign run      = (state == ST_RUN);
    assign clearing = (state == ST_CLEAR);
`else
    localparam logic WAIT_RST = (WAIT_PERIOD == 1);

    assign run      = 1'b1;
    assign clearing = 1'b0;
    assign clr_last = 1'b0;
`endif

    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (WAIT_PERIOD <= 1 || cnt == CNT_W'(WAIT_PERIOD - 1)) begin
            cnt_nxt = '0;
        end
    end

    // wait_q always equals the throttle decode of the count it sits beside,
    // so the stall pattern starts at cnt = 0 on the first running cycle.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt    <= '0;
            wait_q <= WAIT_RST;
        end else if (!run) begin
            cnt    <= '0;
            wait_q <= clr_last ? thr_at('0) : 1'b1;
        end else begin
            cnt    <= cnt_nxt;
            wait_q <= thr_at(cnt_nxt);
        end
    end

    // Reset forces a stall on the same cycle, which also blocks any write
    // that would otherwise land on the reset edge.
    assign stall                = wait_q | srst_i;
    assign amm_rd_waitrequest_o = stall;
    assign amm_wr_waitrequest_o = stall;

    assign rd_accept = amm_rd_read_i  & ~stall;
    assign wr_accept = amm_wr_write_i & ~stall;

    always_ff @(posedge clk_i) begin
`ifdef AMM_MEM_CLEAR_EN
        if (clearing && !srst_i) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < BYTE_CNT; b++) begin
                if (amm_wr_byteenable_i[b]) begin
                    mem[amm_wr_address_i][b*8 +: 8] <= amm_wr_writedata_i[b*8 +: 8];
                end
            end
        end
`else
        if (wr_accept) begin
            for (int b = 0; b < BYTE_CNT; b++) begin
                if (amm_wr_byteenable_i[b]) begin
                    mem[amm_wr_address_i][b*8 +: 8] <= amm_wr_writedata_i[b*8 +: 8];
                end
            end
        end
`endif
    end

    // Sampled before the same-edge write lands, giving read-before-write.
    assign rd_word = mem[amm_rd_address_i];

    amm_rd_latency_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LAT)
    ) u_rd_pipe (
        .clk        (clk_i),
        .flush      (srst_i),
        .push_valid (rd_accept),
        .push_data  (rd_word),
        .ret_valid  (amm_rd_readdatavalid_o),
        .ret_data   (amm_rd_readdata_o)
    );

endmodule

// File: doc/amm_dual_port_mem.md
Name: amm_dual_port_mem

Overview:
- Synthesizable Avalon-MM slave memory that sits directly downstream of the byte-increment engine.
- Serves the engine's read master and write master in the same clock domain.
- Has a fixed-latency read pipeline, byte-enabled writes and deterministic waitrequest throttling.
- Used in the lab top and benches as the memory the engine reads from and writes back to.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; depth is 2**ADDR_WIDTH words.
- BYTE_CNT, DATA_WIDTH/8, number of byteenable bits.
- RD_LATENCY, 2, cycles from an accepted read to readdatavalid; legal range 1..8.
- WAIT_PERIOD, 4, throttle period. Waitrequest is forced high one cycle in every WAIT_PERIOD. 0 disables throttling.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- amm_rd_address_i  in  ADDR_WIDTH  read word address
- amm_rd_read_i  in  1  read request
- amm_rd_readdata_o  out  DATA_WIDTH  read data
- amm_rd_readdatavalid_o  out  1  read data valid
- amm_rd_waitrequest_o  out  1  read port stall
- amm_wr_address_i  in  ADDR_WIDTH  write word address
- amm_wr_write_i  in  1  write request
- amm_wr_writedata_i  in  DATA_WIDTH  write data
- amm_wr_byteenable_i  in  BYTE_CNT  per-byte write enable
- amm_wr_waitrequest_o  out  1  write port stall

Behaviour:
- One clock (clk_i). Reset srst_i is synchronous and active-high.
- Reset values:
  - readdatavalid_o = 0, readdata_o = 0.
  - Both waitrequests = 1 while srst_i is high.
  - The latency pipeline is flushed.
  - The throttle counter is cleared to 0.
- Memory contents are not affected by reset unless AMM_MEM_CLEAR_EN is defined.
- Throttle counter:
  - Free-running, counts 0..WAIT_PERIOD-1 and wraps.
  - thr = (WAIT_PERIOD != 0) && (cnt == WAIT_PERIOD-1).
  - Both waitrequests equal thr, except that the outputs are 1 during reset or clear.
  - Both ports always stall together.
- Waitrequest is a registered output and does not depend combinationally on read or write.
- Read acceptance and data return:
  - A read is accepted when read_i && !rd_waitrequest_o.
  - The address is sampled on the accepting edge.
  - readdatavalid_o is high exactly RD_LATENCY cycles after acceptance, for one cycle, with the word at the sampled address.
  - Back-to-back accepted reads return back-to-back, in order.
  - The pipeline has no backpressure; the master must always accept returned data.
- Write acceptance: a write is accepted when write_i && !wr_waitrequest_o. Bytes with byteenable[i] = 1 are updated; other bytes are kept.
- Same-cycle read and write to the same address: the read returns the old data (read-before-write). The write is visible to any read accepted in a later cycle.
- Address wrap: addresses are used modulo 2**ADDR_WIDTH, with no range check.
- Reset mid-operation: in-flight reads are dropped and no readdatavalid is produced for them. A write accepted on the same edge that srst_i is sampled high is discarded.
- Requests presented while waitrequest is high are ignored. The master must hold the request; the slave keeps no record of it.

Optional Feature:
- Macro AMM_MEM_CLEAR_EN. When defined:
  - After srst_i deasserts, a clear FSM runs: CLEAR -> RUN.
  - CLEAR writes all-zero words to addresses 0..2**ADDR_WIDTH-1, one per cycle, with both waitrequests held at 1.
  - Then RUN is entered, and throttling starts with cnt = 0.
  - srst_i during CLEAR restarts the clear from address 0.
- When not defined: there is no FSM, contents hold their previous value (X at power-up), and waitrequest follows the throttle from the first cycle after reset.

Decomposition:
- Package amm_mem_pkg:
  - state enum for IDLE/CLEAR/RUN;
  - function clog2-safe latency checks;
  - constant MAX_RD_LATENCY = 8.
- Sub-module amm_rd_latency_pipe: RD_LATENCY-deep valid/data shift register with synchronous flush. Instantiated once for the read return path.

Test Plan:
- WAIT_PERIOD=4, hold read_i=1 at address 5 after reset. Waitrequest must be high every 4th cycle; 3 reads are accepted per 4 cycles; each readdatavalid appears exactly 2 cycles after its acceptance.
- Write 0x1122334455667788 to address 3 with byteenable=0xFF, then write 0xAAAAAAAAAAAAAAAA with byteenable=0x0F, then read address 3. Readdata must be 0x11223344AAAAAAAA.
- Same cycle: read address 7 and write 0xFF..FF to address 7, where the old value is 0x0. The read returns 0x0; a following read of address 7 returns 0xFF..FF.
- Accept 2 reads, then assert srst_i for 1 cycle before the data returns. No readdatavalid appears, waitrequest is high during reset, and the throttle restarts from cnt = 0.
- Address 2**ADDR_WIDTH-1 followed by address 0: both return their own data, with no aliasing.
- With AMM_MEM_CLEAR_EN defined and ADDR_WIDTH=4: waitrequest stays high for 16 cycles after reset; afterwards, reads of every address return 0.
